link_rx_packer: RTL and testbench

- Sits directly downstream of the optical-link receiver, in the `clk_link` domain.
- Consumes the receiver's 32-bit word stream and its per-byte K flags.
- Finds SOP/EOP control words, packs pairs of data words into 64-bit beats, and buffers them in an internal FIFO.
- Presents the result as an AXI-Stream master with `tLast`/error marking, ready to be carried to the DMA inbound path.

---
 rtl/link_rx_packer.sv | 257 +++++++++++++++++++++++++
 tb/tb_link_rx_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/link_rx_packer.sv
// link_rx_packer: SOP/EOP framer packing 32-bit link words into 64-bit AXI-Stream beats through a show-ahead FIFO.
// Latency: beat visible on m_tValid 1 cycle after its closing word; backpressure: FIFO absorbs, a full FIFO truncates the frame.
// Build option: define LINK_RX_PACKER_STATS_EN to implement frame_cnt, err_cnt and fifo_ovf (tied 0 otherwise).

module link_rx_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_link,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  input  logic             pop_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push, pop;

  assign pop_vld  = (cnt_q != '0);
  assign pop      = pop_vld && pop_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_rdy = (cnt_q != FULL_CNT) || pop;
  assign push     = push_vld && push_rdy;
  assign pop_dat  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_link) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module link_rx_packer #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         MAX_BEATS  = 256,
  parameter logic [7:0] SOP_CHAR   = 8'h3C,
  parameter logic [7:0] EOP_CHAR   = 8'hDC
) (
  input  logic        clk_link,
  input  logic        reset_n,
  input  logic [31:0] rx_d,
  input  logic [3:0]  rx_k,
  input  logic        rx_v,
  output logic        m_tValid,
  output logic [63:0] m_tData,
  output logic [7:0]  m_tKeep,
  output logic        m_tLast,
  output logic [1:0]  m_tUser,
  input  logic        m_tReady,
  output logic        fifo_ovf,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BEATS);

  state_t        state_q, state_d;
  logic [31:0]   hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [BW-1:0] beats_q, beats_d, beats_inc;
  logic          err_q, err_d;
  logic          term_pend_q, term_pend_d;
  logic [1:0]    term_user_q, term_user_d;

  logic  is_ctl, is_sop, is_eop, is_dat;
  logic  wr_req, term_wr, frame_done, frame_err, drop_err, lost;
  logic  fifo_rdy, push_vld, out_vld;
  beat_t wr_beat, push_dat, out_beat;

  assign is_ctl    = rx_v && (rx_k == 4'b0001);
  assign is_sop    = is_ctl && (rx_d[7:0] == SOP_CHAR);
  assign is_eop    = is_ctl && (rx_d[7:0] == EOP_CHAR);
  assign is_dat    = rx_v && (rx_k == 4'b0000);
  assign beats_inc = beats_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    beats_d     = beats_q;
    err_d       = err_q;
    term_pend_d = term_pend_q;
    term_user_d = term_user_q;
    wr_req      = 1'b0;
    wr_beat     = '0;
    frame_done  = 1'b0;
    frame_err   = 1'b0;
    drop_err    = 1'b0;
    lost        = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_sop) begin
          hold_vld_d = 1'b0;
          if (term_pend_q) begin
            state_d  = DROP;
            drop_err = 1'b1;
          end else begin
            state_d = FRAME;
            beats_d = '0;
            err_d   = 1'b0;
          end
        end
      end
      FRAME: begin
        if (!rx_v) begin
          state_d     = DROP;
          hold_vld_d  = 1'b0;
          term_pend_d = 1'b1;
          term_user_d = 2'b01;
        end else if (is_dat && !hold_vld_q) begin
          hold_d     = rx_d;
          hold_vld_d = 1'b1;
        end else if (is_dat || is_eop) begin
          wr_req     = 1'b1;
          hold_vld_d = 1'b0;
          if (is_dat) begin
            wr_beat.data = {rx_d, hold_q};
            wr_beat.keep = 8'hFF;
          end else begin
            // An empty holder at EOP yields a null closing beat.
            wr_beat.data = hold_vld_q ? {32'h0, hold_q} : 64'h0;
            wr_beat.keep = hold_vld_q ? 8'h0F : 8'h00;
            wr_beat.last = 1'b1;
            wr_beat.user = {1'b0, err_q};
          end
          if (!fifo_rdy) begin
            lost        = 1'b1;
            term_pend_d = 1'b1;
            term_user_d = 2'b01;
            // EOP already consumed, so nothing is left to discard.
            state_d     = is_eop ? IDLE : DROP;
          end else if (is_eop) begin
            frame_done = 1'b1;
            frame_err  = err_q;
            state_d    = IDLE;
          end else begin
            beats_d = beats_inc;
            if (beats_inc == MAX_B) begin
              state_d     = DROP;
              term_pend_d = 1'b1;
              term_user_d = 2'b11;
            end
          end
        end else if (is_sop) begin
          err_d = 1'b1;
        end
      end
      DROP: begin
        if (!rx_v || is_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    term_wr = term_pend_q && !wr_req && fifo_rdy;
    if (term_wr) term_pend_d = 1'b0;
  end

  assign push_vld = (wr_req && fifo_rdy) || term_wr;
  assign push_dat = wr_req ? wr_beat : beat_t'{64'h0, 8'h00, 1'b1, term_user_q};

  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      beats_q     <= '0;
      err_q       <= 1'b0;
      term_pend_q <= 1'b0;
      term_user_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      beats_q     <= beats_d;
      err_q       <= err_d;
      term_pend_q <= term_pend_d;
      term_user_q <= term_user_d;
    end
  end

  link_rx_packer_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_link (clk_link),
    .reset_n  (reset_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (fifo_rdy),
    .pop_vld  (out_vld),
    .pop_dat  (out_beat),
    .pop_rdy  (m_tReady)
  );

  assign m_tValid = out_vld;
  assign m_tData  = out_vld ? out_beat.data : 64'h0;
  assign m_tKeep  = out_vld ? out_beat.keep : 8'h00;
  assign m_tLast  = out_vld && out_beat.last;
  assign m_tUser  = out_vld ? out_beat.user : 2'b00;

`ifdef LINK_RX_PACKER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] err_cnt_q;
  logic        ovf_q;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // An IDLE-state drop and a terminator write can land in the same cycle.
  assign err_inc = {1'b0, drop_err || (frame_done && frame_err)} + {1'b0, term_wr};
  assign err_sum = {1'b0, err_cnt_q} + {15'b0, err_inc};

  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_q + {31'b0, frame_done};
      err_cnt_q   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      ovf_q       <= ovf_q | lost;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign fifo_ovf  = ovf_q;
`else
  logic unused_stats;
  assign unused_stats = ^{frame_done, frame_err, drop_err, lost};
  assign frame_cnt    = '0;
  assign err_cnt      = '0;
  assign fifo_ovf     = 1'b0;
`endif
endmodule

// File: tb/tb_link_rx_packer.sv
// Bench for link_rx_packer: cycle table on a depth-4 instance plus sequences for overflow,
// truncation (MAX_BEATS=2 instance), link loss and mid-frame reset.
module tb_link_rx_packer;
`ifdef LINK_RX_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [3:0]  KC = 4'b0001, KD = 4'b0000;
  localparam logic [31:0] SOPW = 32'h3C, EOPW = 32'hDC, COMW = 32'hBC;

  typedef struct {
    logic v; logic [3:0] k; logic [31:0] d;
    logic ev; logic [63:0] ed; logic [7:0] ek; logic el; logic [1:0] eu;
  } vec_t;

  typedef struct packed {
    logic [63:0] d; logic [7:0] k; logic l; logic [1:0] u;
  } beat_s;

  logic clk_link, reset_n, rx_v, rdy_a, rdy_t;
  logic [31:0] rx_d;
  logic [3:0]  rx_k;
  logic        a_vld, a_last, a_ovf, t_vld, t_last, t_ovf;
  logic [63:0] a_data, t_data;
  logic [7:0]  a_keep, t_keep;
  logic [1:0]  a_user, t_user;
  logic [31:0] a_frame, t_frame;
  logic [15:0] a_err, t_err;

  int n_vec = 0, n_bad = 0;
  beat_s qa[$], qt[$], exp_q[$];
  vec_t  tbl[25];

  link_rx_packer #(.FIFO_DEPTH(4), .MAX_BEATS(256)) dut (
    .clk_link(clk_link), .reset_n(reset_n), .rx_d(rx_d), .rx_k(rx_k), .rx_v(rx_v),
    .m_tValid(a_vld), .m_tData(a_data), .m_tKeep(a_keep), .m_tLast(a_last), .m_tUser(a_user),
    .m_tReady(rdy_a), .fifo_ovf(a_ovf), .frame_cnt(a_frame), .err_cnt(a_err));

  link_rx_packer #(.FIFO_DEPTH(16), .MAX_BEATS(2)) dut_t (
    .clk_link(clk_link), .reset_n(reset_n), .rx_d(rx_d), .rx_k(rx_k), .rx_v(rx_v),
    .m_tValid(t_vld), .m_tData(t_data), .m_tKeep(t_keep), .m_tLast(t_last), .m_tUser(t_user),
    .m_tReady(rdy_t), .fifo_ovf(t_ovf), .frame_cnt(t_frame), .err_cnt(t_err));

  initial clk_link = 1'b0;
  always #5 clk_link = ~clk_link;

  always @(negedge clk_link) begin
    if (a_vld && rdy_a) qa.push_back(beat_s'{a_data, a_keep, a_last, a_user});
    if (t_vld && rdy_t) qt.push_back(beat_s'{t_data, t_keep, t_last, t_user});
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mkv(input logic v, input logic [3:0] k, input logic [31:0] d,
                               input logic ev, input logic [63:0] ed, input logic [7:0] ek,
                               input logic el, input logic [1:0] eu);
    vec_t r;
    r.v = v; r.k = k; r.d = d; r.ev = ev; r.ed = ed; r.ek = ek; r.el = el; r.eu = eu;
    return r;
  endfunction

  function automatic beat_s mkb(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [1:0] u);
    return beat_s'{d, k, l, u};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic check_q(input string nm, input beat_s got[$], input beat_s want[$]);
    n_vec++;
    if (got.size() != want.size()) begin
      n_bad++;
      $display("FAIL %s beat count: got %0d, expected %0d", nm, got.size(), want.size());
    end
    for (int i = 0; i < want.size(); i++) begin
      n_vec++;
      if (i >= got.size() || got[i] !== want[i]) begin
        n_bad++;
        $display("FAIL %s beat %0d: got %h, expected %h", nm, i,
                 (i < got.size()) ? got[i] : beat_s'('x), want[i]);
      end
    end
  endtask

  task automatic put(input logic v, input logic [3:0] k, input logic [31:0] d);
    @(posedge clk_link); #1;
    rx_v = v; rx_k = k; rx_d = d;
  endtask
  task automatic w_sop;                  put(1'b1, KC, SOPW); endtask
  task automatic w_eop;                  put(1'b1, KC, EOPW); endtask
  task automatic w_com;                  put(1'b1, KC, COMW); endtask
  task automatic w_dat(input logic [31:0] d); put(1'b1, KD, d); endtask

  task automatic do_reset;
    @(posedge clk_link); #1;
    reset_n = 1'b0; rx_v = 1'b0; rx_k = 4'h0; rx_d = 32'h0;
    @(posedge clk_link); #1;
    reset_n = 1'b1;
    qa.delete(); qt.delete();
  endtask

  initial begin
    reset_n = 1'b0; rx_v = 1'b0; rx_k = 4'h0; rx_d = 32'h0; rdy_a = 1'b1; rdy_t = 1'b1;
    tbl[0]  = mkv(1'b1, KC, SOPW,         1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[1]  = mkv(1'b1, KD, 32'h11111111, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[2]  = mkv(1'b1, KD, 32'h22222222, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[3]  = mkv(1'b1, KD, 32'h33333333, 1'b1, 64'h2222222211111111, 8'hFF, 1'b0, 2'b00);
    tbl[4]  = mkv(1'b1, KD, 32'h44444444, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[5]  = mkv(1'b1, KC, EOPW,         1'b1, 64'h4444444433333333, 8'hFF, 1'b0, 2'b00);
    tbl[6]  = mkv(1'b1, KC, COMW,         1'b1, 64'h0, 8'h00, 1'b1, 2'b00);
    tbl[7]  = mkv(1'b1, KD, 32'h55555555, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[8]  = mkv(1'b1, 4'b0011, SOPW,    1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[9]  = mkv(1'b1, KD, 32'h66666666, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[10] = mkv(1'b1, KD, 32'h77777777, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[11] = mkv(1'b1, KC, COMW,         1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[12] = mkv(1'b1, KC, SOPW,         1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[13] = mkv(1'b1, KD, 32'hAAAAAAAA, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[14] = mkv(1'b1, KD, 32'hBBBBBBBB, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[15] = mkv(1'b1, KD, 32'hCCCCCCCC, 1'b1, 64'hBBBBBBBBAAAAAAAA, 8'hFF, 1'b0, 2'b00);
    tbl[16] = mkv(1'b1, KC, EOPW,         1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[17] = mkv(1'b1, KC, COMW,         1'b1, 64'h00000000CCCCCCCC, 8'h0F, 1'b1, 2'b00);
    tbl[18] = mkv(1'b1, KC, SOPW,         1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[19] = mkv(1'b1, KD, 32'h12345678, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[20] = mkv(1'b1, KC, SOPW,         1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[21] = mkv(1'b1, KD, 32'h9ABCDEF0, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00);
    tbl[22] = mkv(1'b1, KC, EOPW,         1'b1, 64'h9ABCDEF012345678, 8'hFF, 1'b0, 2'b00);
    tbl[23] = mkv(1'b1, KC, COMW,         1'b1, 64'h0, 8'h00, 1'b1, 2'b01);
    tbl[24] = mkv(1'b0, KD, 32'h0,        1'b0, 64'h0, 8'h00, 1'b0, 2'b00);

    // Reset state
    repeat (2) @(posedge clk_link);
    #1;
    chk("reset tValid", {63'h0, a_vld}, 64'h0);
    chk("reset tData", a_data, 64'h0);
    chk("reset keep/last/user", {53'h0, a_keep, a_last, a_user}, 64'h0);
    chk("reset counters", {a_frame, a_err, 15'h0, a_ovf}, 64'h0);
    reset_n = 1'b1;

    // Cycle-accurate table with m_tReady held high
    for (int i = 0; i < 25; i++) begin
      put(tbl[i].v, tbl[i].k, tbl[i].d);
      @(negedge clk_link);
      n_vec++;
      if (a_vld !== tbl[i].ev ||
          (tbl[i].ev && {a_data, a_keep, a_last, a_user} !== {tbl[i].ed, tbl[i].ek, tbl[i].el, tbl[i].eu})) begin
        n_bad++;
        $display("FAIL table row %0d: got vld=%b data=%h keep=%h last=%b user=%b, expected vld=%b data=%h keep=%h last=%b user=%b",
                 i, a_vld, a_data, a_keep, a_last, a_user,
                 tbl[i].ev, tbl[i].ed, tbl[i].ek, tbl[i].el, tbl[i].eu);
      end
    end
    chk("table frame_cnt", {32'h0, a_frame}, STATS ? 64'd3 : 64'd0);
    chk("table err_cnt", {48'h0, a_err}, STATS ? 64'd1 : 64'd0);
    chk("table fifo_ovf", {63'h0, a_ovf}, 64'h0);

    // FIFO overflow under backpressure, then a second frame dropped while the terminator is pending
    do_reset;
    @(posedge clk_link); #1; rdy_a = 1'b0;
    w_sop;
    for (int i = 0; i < 12; i++) w_dat(32'hA0000000 + i);
    w_eop;
    w_sop; w_dat(32'hF1F1F1F1); w_dat(32'hF2F2F2F2); w_eop;
    w_com;
    @(negedge clk_link);
    chk("ovf held tValid", {63'h0, a_vld}, 64'h1);
    chk("ovf held tData", a_data, 64'hA0000001A0000000);
    chk("ovf sticky", {63'h0, a_ovf}, STATS ? 64'd1 : 64'd0);
    chk("ovf drop err_cnt", {48'h0, a_err}, STATS ? 64'd1 : 64'd0);
    w_com; w_com;
    @(negedge clk_link);
    chk("ovf stable tData", a_data, 64'hA0000001A0000000);
    @(posedge clk_link); #1; rdy_a = 1'b1;
    repeat (8) w_com;
    exp_q = '{mkb(64'hA0000001A0000000, 8'hFF, 1'b0, 2'b00),
              mkb(64'hA0000003A0000002, 8'hFF, 1'b0, 2'b00),
              mkb(64'hA0000005A0000004, 8'hFF, 1'b0, 2'b00),
              mkb(64'hA0000007A0000006, 8'hFF, 1'b0, 2'b00),
              mkb(64'h0, 8'h00, 1'b1, 2'b01)};
    check_q("overflow", qa, exp_q);
    chk("ovf err_cnt", {48'h0, a_err}, STATS ? 64'd2 : 64'd0);
    chk("ovf frame_cnt", {32'h0, a_frame}, 64'h0);

    // Truncation at MAX_BEATS=2, then a clean short frame
    do_reset;
    w_sop;
    for (int i = 0; i < 6; i++) w_dat(32'hB0000000 + i);
    w_eop;
    w_sop; w_dat(32'hC0FFEE01); w_eop;
    repeat (6) w_com;
    exp_q = '{mkb(64'hB0000001B0000000, 8'hFF, 1'b0, 2'b00),
              mkb(64'hB0000003B0000002, 8'hFF, 1'b0, 2'b00),
              mkb(64'h0, 8'h00, 1'b1, 2'b11),
              mkb(64'h00000000C0FFEE01, 8'h0F, 1'b1, 2'b00)};
    check_q("truncate", qt, exp_q);
    chk("trunc err_cnt", {48'h0, t_err}, STATS ? 64'd1 : 64'd0);
    chk("trunc frame_cnt", {32'h0, t_frame}, STATS ? 64'd1 : 64'd0);

    // Link loss after 3 words, then recovery
    do_reset;
    w_sop;
    for (int i = 0; i < 3; i++) w_dat(32'hD0000000 + i);
    put(1'b0, KD, 32'h0); put(1'b0, KD, 32'h0);
    w_sop; w_dat(32'hE0000001); w_dat(32'hE0000002); w_eop;
    repeat (6) w_com;
    exp_q = '{mkb(64'hD0000001D0000000, 8'hFF, 1'b0, 2'b00),
              mkb(64'h0, 8'h00, 1'b1, 2'b01),
              mkb(64'hE0000002E0000001, 8'hFF, 1'b0, 2'b00),
              mkb(64'h0, 8'h00, 1'b1, 2'b00)};
    check_q("link loss", qa, exp_q);
    chk("loss err_cnt", {48'h0, a_err}, STATS ? 64'd1 : 64'd0);

    // Reset with 3 beats buffered
    @(posedge clk_link); #1; rdy_a = 1'b0;
    w_sop;
    for (int i = 0; i < 6; i++) w_dat(32'h60000000 + i);
    w_com;
    @(negedge clk_link);
    chk("pre-reset tValid", {63'h0, a_vld}, 64'h1);
    @(posedge clk_link); #1;
    reset_n = 1'b0;
    #1;
    chk("mid reset tValid", {63'h0, a_vld}, 64'h0);
    chk("mid reset tData", a_data, 64'h0);
    chk("mid reset counters", {a_frame, a_err, 15'h0, a_ovf}, 64'h0);
    @(posedge clk_link); #1;
    reset_n = 1'b1; rdy_a = 1'b1;
    qa.delete();
    w_sop; w_dat(32'h70000000); w_dat(32'h70000001); w_eop;
    repeat (6) w_com;
    exp_q = '{mkb(64'h7000000170000000, 8'hFF, 1'b0, 2'b00),
              mkb(64'h0, 8'h00, 1'b1, 2'b00)};
    check_q("after reset", qa, exp_q);
    chk("after reset frame_cnt", {32'h0, a_frame}, STATS ? 64'd1 : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
